// File: rtl/lsu_byte.sv
// Byte load/store unit (LB/SB) for the MEM stage: one access at a time, using a
// req/ack handshake to a word-wide data memory. Optional watchdog: LSU_TIMEOUT_EN.
module lsu_byte #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              store_q, store_d;
  logic [1:0]        lane_q, lane_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [7:0]        ld_byte;

`ifdef LSU_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       unused_wdata;
  assign unused_wdata = ^req_wdata[31:8];
`else
  logic       unused_wdata;
  assign unused_wdata = ^{req_wdata[31:8], 8'(TIMEOUT_CYCLES)};
`endif

  assign ld_byte = mem_rdata[{lane_q, 3'b000} +: 8];

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      store_q <= 1'b0;
      lane_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      cnt_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      store_q <= store_d;
      lane_q  <= lane_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Next-state and capture logic
  always_comb begin
    state_d = state_q;
    store_d = store_q;
    lane_d  = lane_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          store_d = req_store;
          lane_d  = req_addr[1:0];
          addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
          wdata_d = {4{req_wdata[7:0]}};
          state_d = MEM;
`ifdef LSU_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end
      end
      MEM: begin
        if (mem_ack) begin
          rdata_d = store_q ? 32'd0 : {{24{ld_byte[7]}}, ld_byte};
          err_d   = 1'b0;
          state_d = RESP;
        end
`ifdef LSU_TIMEOUT_EN
        // An ack arriving on the limit cycle takes priority over the abort
        else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
          rdata_d = 32'd0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the state register or driven by capture registers
  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign mem_req   = (state_q == MEM);
  assign mem_we    = (state_q == MEM) && store_q;
  assign mem_be    = (state_q == MEM) ? (4'b0001 << lane_q) : 4'b0000;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_byte.sv
// Self-checking bench for lsu_byte: directed cases plus randomized LB/SB traffic
// checked against a per-transaction behavioural model.
module tb_lsu_byte;

  localparam int unsigned TO_CYC = 16;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_store;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err, busy;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int n_vec = 0;
  int n_err = 0;

  lsu_byte #(.ADDR_W(32), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_req(input logic st, input logic [31:0] a, input logic [31:0] w);
    req_valid = 1'b1;
    req_store = st;
    req_addr  = a;
    req_wdata = w;
  endtask

  // Model: one access, ack after dly wait cycles, optional held follow-on request.
  task automatic run_txn(input logic st, input logic [31:0] a, input logic [31:0] w,
                         input int dly, input logic [31:0] rd, input logic hold,
                         input logic n_st, input logic [31:0] n_a, input logic [31:0] n_w);
    logic [3:0]  exp_be;
    logic [7:0]  b;
    logic [31:0] exp_rd;
    int          sh;
    sh     = 8 * int'(a[1:0]);
    exp_be = 4'(1 << a[1:0]);
    b      = 8'(rd >> sh);
    if (st)        exp_rd = 32'd0;
    else if (b[7]) exp_rd = 32'hFFFF_FF00 | 32'(b);
    else           exp_rd = 32'(b);

    check("ready_idle", req_ready, 1'b1);
    drive_req(st, a, w);
    @(negedge clk);
    for (int k = 0; k <= dly; k++) begin
      check("mem_req", mem_req, 1'b1);
      check("mem_we", mem_we, st);
      check("mem_addr", mem_addr, {a[31:2], 2'b00});
      check("mem_be", mem_be, exp_be);
      if (st) check("mem_wdata", mem_wdata, {4{w[7:0]}});
      check("ready_busy", req_ready, 1'b0);
      check("busy_mem", busy, 1'b1);
      check("rsp_v_mem", rsp_valid, 1'b0);
      if (hold) drive_req(n_st, n_a, n_w);
      else      req_valid = 1'b0;
      mem_ack   = (k == dly);
      mem_rdata = (k == dly) ? rd : $urandom;
      @(negedge clk);
    end
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    check("rsp_valid", rsp_valid, 1'b1);
    check("rsp_rdata", rsp_rdata, exp_rd);
    check("rsp_err", rsp_err, 1'b0);
    check("ready_resp", req_ready, 1'b0);
    check("mem_req_resp", mem_req, 1'b0);
    check("mem_be_resp", mem_be, 4'b0000);
    check("mem_we_resp", mem_we, 1'b0);
    @(negedge clk);
    check("rsp_v_idle", rsp_valid, 1'b0);
    check("busy_idle", busy, 1'b0);
    check("rdata_hold", rsp_rdata, exp_rd);
    check("mem_req_idle", mem_req, 1'b0);
  endtask

  task automatic reset_mid_op();
    drive_req(1'b0, $urandom, $urandom);
    mem_ack = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_pre_req", mem_req, 1'b1);
    #2 rst_n = 1'b0;
    req_valid = 1'b1;
    #1;
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rsp_v", rsp_valid, 1'b0);
    check("rst_ready", req_ready, 1'b1);
    check("rst_mem_be", mem_be, 4'b0000);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    @(negedge clk);
    check("rst_no_accept", busy, 1'b0);
    rst_n     = 1'b1;
    req_valid = 1'b0;
    mem_ack   = 1'b1;
    @(negedge clk);
    check("late_ack_rsp", rsp_valid, 1'b0);
    check("late_ack_busy", busy, 1'b0);
    mem_ack = 1'b0;
    @(negedge clk);
    check("late_ack_rsp2", rsp_valid, 1'b0);
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic timeout_case();
    int cnt;
    drive_req(1'b0, 32'h0000_0333, 32'd0);
    mem_ack = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    cnt = 0;
    while (mem_req && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    check("to_cycles", 32'(cnt), 32'(TO_CYC));
    check("to_rsp_valid", rsp_valid, 1'b1);
    check("to_rsp_err", rsp_err, 1'b1);
    check("to_rsp_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    check("to_idle", busy, 1'b0);
  endtask
`endif

  logic        c_st, n_st, hold;
  logic [31:0] c_a, c_w, n_a, n_w;

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b1;
    req_store = 1'b0;
    req_addr  = 32'h0000_0104;
    req_wdata = 32'd0;
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    #1;
    check("reset_ready", req_ready, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_mem_req", mem_req, 1'b0);
    check("reset_rsp_v", rsp_valid, 1'b0);
    check("reset_rdata", rsp_rdata, 32'd0);
    check("reset_err", rsp_err, 1'b0);
    check("reset_mem_be", mem_be, 4'b0000);
    check("reset_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("reset_no_accept", busy, 1'b0);
    rst_n     = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);

    run_txn(1'b0, 32'h0000_0103, 32'hDEAD_BEEF, 0, 32'h8011_2233, 1'b0, 1'b0, 32'd0, 32'd0);
    run_txn(1'b0, 32'h0000_0101, 32'h0, 0, 32'h0000_7F00, 1'b0, 1'b0, 32'd0, 32'd0);
    run_txn(1'b1, 32'h0000_0202, 32'h1234_5678, 0, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, 32'd0);
    run_txn(1'b0, 32'hFFFF_FFFC, 32'h0, 5, 32'h0000_00C3, 1'b1, 1'b1, 32'h0000_0457, 32'h0000_00A5);
    run_txn(1'b1, 32'h0000_0457, 32'h0000_00A5, 0, 32'h0, 1'b0, 1'b0, 32'd0, 32'd0);

    reset_mid_op();

`ifdef LSU_TIMEOUT_EN
    timeout_case();
    run_txn(1'b0, 32'h0000_0010, 32'h0, 0, 32'h0000_0055, 1'b0, 1'b0, 32'd0, 32'd0);
    run_txn(1'b0, 32'h0000_0012, 32'h0, int'(TO_CYC) - 1, 32'h0081_0000, 1'b0, 1'b0, 32'd0, 32'd0);
`endif

    c_st = 1'($urandom_range(0, 1));
    c_a  = $urandom;
    c_w  = $urandom;
    for (int i = 0; i < 150; i++) begin
      n_st = 1'($urandom_range(0, 1));
      n_a  = $urandom;
      n_w  = $urandom;
      hold = 1'($urandom_range(0, 1));
      run_txn(c_st, c_a, c_w, int'($urandom_range(0, 7)), $urandom, hold, n_st, n_a, n_w);
      c_st = n_st;
      c_a  = n_a;
      c_w  = n_w;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_byte.md
Name: lsu_byte

Overview:
- Byte load/store unit in the MEM stage, directly downstream of the ALU.
- Consumes the ALU result as the effective address for LB/SB and drives a word-wide data memory with byte enables.
- Uses a req/ack handshake to the memory, so variable memory latency is supported.
- Returns the sign-extended load byte to writeback.

Parameters:
- ADDR_W, 32, width of effective address and memory address.
- TIMEOUT_CYCLES, 16, cycles in MEM without mem_ack before abort. Used only when LSU_TIMEOUT_EN is defined; legal range 1..255.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  EX stage presents an access
- req_ready  out  1  unit can accept; transfer occurs when req_valid && req_ready at a rising edge
- req_store  in  1  1 = SB, 0 = LB
- req_addr  in  ADDR_W  effective address (ALU result)
- req_wdata  in  32  store data; only bits [7:0] used
- rsp_valid  out  1  one-cycle pulse, response available
- rsp_rdata  out  32  LB: sign-extended byte; SB: 0
- rsp_err  out  1  access aborted by timeout; constant 0 without LSU_TIMEOUT_EN
- busy  out  1  state != IDLE
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  word address {addr[ADDR_W-1:2],2'b00}
- mem_be  out  4  byte enable, one-hot on lane addr[1:0]
- mem_wdata  out  32  {4{wdata[7:0]}}
- mem_ack  in  1  memory completes the access this cycle
- mem_rdata  in  32  read word; valid when mem_ack && !mem_we

Behaviour:
- Reset (rst_n low, async):
  - state = IDLE; req_ready = 1.
  - rsp_valid, rsp_rdata, rsp_err, busy, mem_req, mem_we, mem_addr, mem_be, mem_wdata = 0.
  - Requests presented while rst_n is low are not accepted.
- FSM states: IDLE, MEM, RESP.
- IDLE:
  - req_ready = 1.
  - On accept: capture store flag, lane = addr[1:0], word address and store byte; go to MEM.
- MEM:
  - mem_req = 1; mem_we, mem_addr, mem_be, mem_wdata driven from captured registers and held stable until ack.
  - On mem_ack (allowed in the first MEM cycle):
    - LB: byte = mem_rdata[8*lane+7 : 8*lane]; rsp_rdata = {{24{byte[7]}}, byte}.
    - SB: rsp_rdata = 0.
    - Go to RESP.
- RESP:
  - rsp_valid = 1 for exactly one cycle; req_ready = 0; go to IDLE.
  - No backpressure: writeback always consumes the response.
- Latency:
  - Accept at edge N; mem_req high in cycle N+1.
  - With an ack in that cycle, rsp_valid is high in cycle N+2.
  - Minimum initiation interval is 3 cycles.
- rsp_rdata and rsp_err hold their value until the next response is produced.
- mem_req, mem_we and mem_be are 0 outside MEM. mem_addr and mem_wdata may hold stale values outside MEM.
- mem_ack outside MEM is ignored.
- req_valid held while busy: not accepted. The same request is accepted on the first IDLE cycle.
- All outputs are registered or decoded from the state register; there is no combinational path from req_* to mem_*.
- Reset mid-operation: immediate return to IDLE with reset values. A pending memory access is abandoned and mem_req falls asynchronously.
- Address wrap: no arithmetic is done on the address; upper bits pass through unchanged.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to MEM and increments each MEM cycle without mem_ack.
  - When the counter reaches TIMEOUT_CYCLES without ack: mem_req drops, state goes to RESP, rsp_err = 1, rsp_rdata = 0.
  - A successful response sets rsp_err = 0.
  - mem_ack in the same cycle the limit is reached wins; that access completes normally.
- Not defined:
  - MEM waits indefinitely for mem_ack.
  - rsp_err is tied 0 and no counter logic exists.

Test Plan:
- LB, req_addr=0x103, mem_rdata=0x80112233, ack in first MEM cycle -> mem_addr=0x100, mem_be=4'b1000, mem_we=0, rsp_valid two cycles after accept, rsp_rdata=0xFFFFFF80.
- LB, req_addr=0x101, mem_rdata=0x00007F00 -> mem_be=4'b0010, rsp_rdata=0x0000007F.
- SB, req_addr=0x202, req_wdata=0x12345678 -> mem_we=1, mem_addr=0x200, mem_be=4'b0100, mem_wdata=0x78787878, rsp_rdata=0.
- mem_ack delayed 5 cycles while req_valid stays high with a second request -> mem_req and mem_addr stable 5 cycles, req_ready=0 throughout, second request accepted only after the RESP cycle.
- rst_n pulsed low during MEM -> mem_req, busy, rsp_valid = 0 immediately, req_ready=1. A later ack produces no response.
- LSU_TIMEOUT_EN, TIMEOUT_CYCLES=16, no mem_ack -> mem_req falls after 16 MEM cycles, rsp_valid=1 with rsp_err=1 and rsp_rdata=0. A following normal LB returns rsp_err=0.
